// File: rtl/load_queue_fu_pkg.sv
// Shared types for the in-order load queue: memory size encoding, entry state and entry layout.
// Also provides the RV32 I-immediate sign-extension macro used at address generation.
`ifndef LOAD_QUEUE_FU_PKG_SV
`define LOAD_QUEUE_FU_PKG_SV

`define RV32_signext_Iimm(inst) {{20{inst[31]}}, inst[31:20]}

package load_queue_fu_pkg;

  localparam int LQ_XLEN      = 32;
  localparam int LQ_ROB_TAG_W = 5;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } MEM_SIZE;

  typedef enum logic [1:0] {
    LQ_EMPTY = 2'd0,
    LQ_WAIT  = 2'd1,
    LQ_DONE  = 2'd2
  } LQ_STATE;

  typedef struct packed {
    LQ_STATE                   state;
    logic [LQ_ROB_TAG_W-1:0]   rob_tag;
    logic [LQ_XLEN-1:0]        addr;
    logic [2:0]                funct3;
    logic [LQ_XLEN-1:0]        value;
  } LQ_ENTRY;

  function automatic logic [2:0] load_funct3(input logic [31:0] inst);
    return inst[14:12];
  endfunction

endpackage

`endif

// File: rtl/load_extend.sv
// Combinational load-data extension: selects byte/half/word by funct3[1:0] and
// zero-extends (funct3[2]=1) or sign-extends (funct3[2]=0) to XLEN.
module load_extend
  import load_queue_fu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_value
);

  logic w_zext;
  assign w_zext = i_funct3[2];

  // Size select and extension; DOUBLE is not a legal RV32 load and passes raw data.
  always_comb begin
    o_value = i_data;
    case (MEM_SIZE'(i_funct3[1:0]))
      BYTE: begin
        if (w_zext) begin
          o_value = {{(XLEN-8){1'b0}}, i_data[7:0]};
        end else begin
          o_value = {{(XLEN-8){i_data[7]}}, i_data[7:0]};
        end
      end
      HALF: begin
        if (w_zext) begin
          o_value = {{(XLEN-16){1'b0}}, i_data[15:0]};
        end else begin
          o_value = {{(XLEN-16){i_data[15]}}, i_data[15:0]};
        end
      end
      WORD:    o_value = i_data;
      default: o_value = i_data;
    endcase
  end

endmodule

// File: rtl/load_queue_fu.sv
// In-order multi-entry load unit: allocate at tail, issue one memory request at a time
// from iss, retire extended results from head through a done/ack handshake.
module load_queue_fu
  import load_queue_fu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int ROB_TAG_W = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 squash,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROB_TAG_W-1:0] in_rob_tag,
  input  logic [XLEN-1:0]      in_rs1,
  input  logic [31:0]          in_inst,
  output logic                 mem_req,
  output logic [XLEN-1:0]      mem_addr,
  output logic [1:0]           mem_size,
  input  logic                 mem_ack,
  input  logic [XLEN-1:0]      mem_data,
  output logic                 out_done,
  output logic [ROB_TAG_W-1:0] out_rob_tag,
  output logic [XLEN-1:0]      out_value,
  input  logic                 out_ack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  LQ_ENTRY          r_entry [DEPTH];
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W-1:0] r_iss;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W:0]   r_count;

  logic             w_accept;
  logic             w_mem_fire;
  logic             w_retire;
  logic [XLEN-1:0]  w_addr;
  logic [XLEN-1:0]  w_ext_value;
  logic [2:0]       w_funct3;
  logic             w_unused_inst;

  assign w_unused_inst = ^{in_inst[31:20], in_inst[19:15], in_inst[11:0]} & 1'b0;
  assign w_funct3      = load_funct3(in_inst);
  assign w_addr        = in_rs1 + `RV32_signext_Iimm(in_inst);

  // in_ready looks only at the registered count, so a same-cycle retire never frees a slot early.
  assign in_ready   = (r_count < CNT_FULL);
  assign w_accept   = in_valid && in_ready && !squash;
  assign mem_req    = (r_entry[r_iss].state == LQ_WAIT) && !squash;
  assign mem_addr   = r_entry[r_iss].addr;
  assign mem_size   = r_entry[r_iss].funct3[1:0];
  assign w_mem_fire = mem_req && mem_ack;

  assign out_done    = (r_entry[r_head].state == LQ_DONE);
  assign out_rob_tag = r_entry[r_head].rob_tag;
  assign out_value   = r_entry[r_head].value;
  assign w_retire    = out_done && out_ack && !squash;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .i_data   (mem_data),
    .i_funct3 (r_entry[r_iss].funct3),
    .o_value  (w_ext_value)
  );

  // Entry array, pointers and occupancy; tail, iss and head slots never coincide when written.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '0;
      end
      r_tail  <= '0;
      r_iss   <= '0;
      r_head  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_entry[r_tail].state   <= LQ_WAIT;
        r_entry[r_tail].rob_tag <= in_rob_tag;
        r_entry[r_tail].addr    <= w_addr;
        r_entry[r_tail].funct3  <= w_funct3;
        r_entry[r_tail].value   <= '0;
        r_tail                  <= r_tail + PTR_W'(1);
      end
      if (w_mem_fire) begin
        r_entry[r_iss].state <= LQ_DONE;
        r_entry[r_iss].value <= w_ext_value;
        r_iss                <= r_iss + PTR_W'(1);
      end
      if (w_retire) begin
        r_entry[r_head].state <= LQ_EMPTY;
        r_head                <= r_head + PTR_W'(1);
      end
      case ({w_accept, w_retire})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_load_queue_fu.sv
// Scoreboard bench for load_queue_fu: directed loads push expected {tag,value};
// a negedge monitor pops and compares on every out_done/out_ack handshake.
module tb_load_queue_fu;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] val;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        squash = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rob_tag = 5'd0;
  logic [31:0] in_rs1 = 32'd0;
  logic [31:0] in_inst = 32'd0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = 32'd0;
  logic        out_done;
  logic [4:0]  out_rob_tag;
  logic [31:0] out_value;
  logic        out_ack = 1'b0;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  localparam logic [31:0] K = 32'hA5A50000;

  load_queue_fu dut (
    .clock(clock), .reset(reset), .squash(squash),
    .in_valid(in_valid), .in_ready(in_ready), .in_rob_tag(in_rob_tag),
    .in_rs1(in_rs1), .in_inst(in_inst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_ack(mem_ack), .mem_data(mem_data),
    .out_done(out_done), .out_rob_tag(out_rob_tag), .out_value(out_value),
    .out_ack(out_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every consumed head result must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && out_done && out_ack) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: tag %0d value 0x%08h with empty scoreboard", out_rob_tag, out_value);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_tag", {27'd0, out_rob_tag}, {27'd0, e.tag});
        chk("sb_value", out_value, e.val);
      end
    end
  end

  function automatic logic [31:0] mk_inst(input logic [11:0] imm, input logic [2:0] f3);
    return {imm, 5'd1, f3, 5'd2, 7'b0000011};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [4:0] tag, input logic [31:0] rs1, input logic [11:0] imm,
                       input logic [2:0] f3, input logic [31:0] expv, input bit push);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_rob_tag = tag; in_rs1 = rs1; in_inst = mk_inst(imm, f3);
    for (int c = 0; c < 50 && !ok; c++) begin
      if (in_ready) ok = 1'b1;
      step();
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: tag %0d never accepted", tag);
    end else if (push) begin
      sb.push_back('{tag: tag, val: expv});
    end
  endtask

  task automatic mem_respond(input logic [31:0] data);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (mem_req) ok = 1'b1;
      else step();
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL mem_req_timeout: got 0 expected 1");
    end else begin
      mem_ack = 1'b1; mem_data = data;
      step();
      mem_ack = 1'b0;
    end
  endtask

  task automatic retire();
    bit ok;
    ok = 1'b0;
    out_ack = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (out_done) ok = 1'b1;
      step();
    end
    out_ack = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL out_done_timeout: got 0 expected 1");
    end
  endtask

  initial begin
    int n_iss;
    int cyc;
    // Reset state
    repeat (3) step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_out_done", {31'd0, out_done}, 32'd0);
    chk("rst_out_tag", {27'd0, out_rob_tag}, 32'd0);
    chk("rst_out_value", out_value, 32'd0);
    reset = 1'b0;
    step();

    // 1. Single LW with latency checks
    in_valid = 1'b1; in_rob_tag = 5'd3; in_rs1 = 32'h100; in_inst = mk_inst(12'd4, 3'b010);
    chk("t1_req_before_accept", {31'd0, mem_req}, 32'd0);
    step();
    in_valid = 1'b0;
    sb.push_back('{tag: 5'd3, val: 32'hDEADBEEF});
    chk("t1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h104);
    chk("t1_mem_size", {30'd0, mem_size}, 32'd2);
    mem_ack = 1'b1; mem_data = 32'hDEADBEEF;
    step();
    mem_ack = 1'b0;
    chk("t1_out_done", {31'd0, out_done}, 32'd1);
    chk("t1_req_after_ack", {31'd0, mem_req}, 32'd0);
    retire();
    chk("t1_done_cleared", {31'd0, out_done}, 32'd0);

    // 2. Extension variants, upper data bits deliberately non-zero
    issue(5'd1, 32'h200, 12'hFFC, 3'b000, 32'hFFFFFF80, 1'b1);
    chk("t2_neg_imm_addr", mem_addr, 32'h1FC);
    chk("t2_lb_size", {30'd0, mem_size}, 32'd0);
    mem_respond(32'h7FFFFF80); retire();
    issue(5'd2, 32'h200, 12'd0, 3'b100, 32'h00000080, 1'b1);
    mem_respond(32'hFFFFFF80); retire();
    issue(5'd4, 32'h200, 12'd2, 3'b001, 32'hFFFF8001, 1'b1);
    chk("t2_lh_size", {30'd0, mem_size}, 32'd1);
    mem_respond(32'h12348001); retire();
    issue(5'd5, 32'h200, 12'd2, 3'b101, 32'h00008001, 1'b1);
    mem_respond(32'hFFFF8001); retire();

    // 3. Fill the queue, extra request ignored, retire order
    for (int i = 0; i < 4; i++)
      issue(5'(10 + i), 32'h600 + 32'(i * 4), 12'd0, 3'b010, 32'h60000000 + 32'(i), 1'b1);
    chk("t3_full_not_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; in_rob_tag = 5'd14; in_rs1 = 32'h700; in_inst = mk_inst(12'd0, 3'b010);
    step(); step();
    in_valid = 1'b0;
    chk("t3_still_full", {31'd0, in_ready}, 32'd0);
    chk("t3_head_addr", mem_addr, 32'h600);
    mem_respond(32'h60000000); retire();
    chk("t3_ready_again", {31'd0, in_ready}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      mem_respond(32'h60000000 + 32'(i)); retire();
    end

    // 4. Back-pressure on the result port
    issue(5'd20, 32'h500, 12'd0, 3'b010, 32'h11111111, 1'b1);
    issue(5'd21, 32'h504, 12'd0, 3'b010, 32'h22222222, 1'b1);
    mem_respond(32'h11111111);
    chk("t4_second_addr", mem_addr, 32'h504);
    mem_respond(32'h22222222);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_done", {31'd0, out_done}, 32'd1);
      chk("t4_hold_tag", {27'd0, out_rob_tag}, 32'd20);
      chk("t4_hold_value", out_value, 32'h11111111);
      step();
    end
    retire();
    chk("t4_second_tag", {27'd0, out_rob_tag}, 32'd21);
    retire();

    // 5. Squash with simultaneous mem_ack and accept
    issue(5'd7, 32'h300, 12'd0, 3'b010, 32'd0, 1'b0);
    chk("t5_req_pre_squash", {31'd0, mem_req}, 32'd1);
    squash = 1'b1; mem_ack = 1'b1; mem_data = 32'h77777777;
    in_valid = 1'b1; in_rob_tag = 5'd9; in_rs1 = 32'h900; in_inst = mk_inst(12'd0, 3'b010);
    step();
    squash = 1'b0; mem_ack = 1'b0; in_valid = 1'b0;
    chk("t5_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t5_out_done", {31'd0, out_done}, 32'd0);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    step(); step();
    chk("t5_stay_idle", {30'd0, mem_req, out_done}, 32'd0);
    issue(5'd8, 32'h400, 12'h010, 3'b010, 32'hCAFEF00D, 1'b1);
    chk("t5_fresh_addr", mem_addr, 32'h410);
    mem_respond(32'hCAFEF00D); retire();

    // 6. Streaming wrap: 2*DEPTH+1 loads, ack when requested, immediate out_ack
    n_iss = 0; cyc = 0;
    out_ack = 1'b1;
    while (!(n_iss == 9 && sb.size() == 0) && cyc < 300) begin
      if (n_iss < 9 && in_ready) begin
        in_valid = 1'b1; in_rob_tag = 5'(n_iss);
        in_rs1 = 32'h1000 + 32'(n_iss * 16); in_inst = mk_inst(12'd8, 3'b010);
        sb.push_back('{tag: 5'(n_iss), val: (32'h1008 + 32'(n_iss * 16)) ^ K});
        n_iss++;
      end else begin
        in_valid = 1'b0;
      end
      mem_ack = mem_req;
      mem_data = mem_addr ^ K;
      step();
      cyc++;
    end
    in_valid = 1'b0; mem_ack = 1'b0; out_ack = 1'b0;
    chk("t6_all_issued", 32'(n_iss), 32'd9);
    chk("t6_scoreboard_empty", 32'(sb.size()), 32'd0);
    step();
    chk("t6_idle_done", {31'd0, out_done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
